// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: the combinational ROM port plus the IF/ID slot
// handshake towards decode.
//
// Handshake: the slot (id_valid_o/id_pc_o/id_inst_o) is offered while
// id_valid_o=1 and is consumed on a rising edge where id_valid_o && id_ready_i.
// While id_valid_o=1 && !id_ready_i the slot contents are held stable.
// id_ready_i may be driven regardless of id_valid_o.
interface if_stage_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_o;
  logic [DATA_W-1:0] inst_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_inst_o;

  // Fetch stage side.
  modport master (
    output pc_o,
    input  inst_i,
    output id_valid_o,
    input  id_ready_i,
    output id_pc_o,
    output id_inst_o
  );

  // ROM/decode side.
  modport slave (
    input  pc_o,
    output inst_i,
    input  id_valid_o,
    output id_ready_i,
    input  id_pc_o,
    input  id_inst_o
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, reads the combinational ROM and
// fills the IF/ID slot under valid/ready, with redirect flush and halt.
module if_stage #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  if_stage_if.master        bus,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  output logic [31:0]       fetch_cnt_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [DATA_W-1:0] id_inst_q, id_inst_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              load;
  logic              accept;

  assign load   = (state_q != S_HALT) && !halt_i && (!valid_q || bus.id_ready_i);
  assign accept = valid_q && bus.id_ready_i;

  // Next-state logic; redirect forces RUN from any state.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (halt_i)                          state_d = S_HALT;
          else if (valid_q && !bus.id_ready_i) state_d = S_STALL;
        end
        S_STALL: begin
          if (bus.id_ready_i) state_d = halt_i ? S_HALT : S_RUN;
        end
        S_HALT: begin
          if (!halt_i) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Datapath next values: redirect beats load, load beats drain/hold.
  always_comb begin
    pc_d      = pc_q;
    valid_d   = valid_q;
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    cnt_d     = cnt_q;
    if (redirect_i) begin
      // The ROM word fetched this cycle belongs to the wrong path; drop it.
      pc_d      = redirect_pc_i;
      valid_d   = 1'b0;
      id_inst_d = NOP_INST;
    end else if (load) begin
      id_inst_d = bus.inst_i;
      id_pc_d   = pc_q;
      valid_d   = 1'b1;
      pc_d      = pc_q + ADDR_W'(1);
    end else if (accept) begin
      // Halted: decode took the last word, nothing replaces it.
      valid_d = 1'b0;
    end
    if (accept && !redirect_i) cnt_d = cnt_q + 32'd1;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.id_valid_o = valid_q;
  assign bus.id_pc_o    = id_pc_q;
  assign bus.id_inst_o  = id_inst_q;
  assign fetch_cnt_o    = cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational ROM model.
module tb_if_stage;

  localparam logic [1:0]  ST_RUN   = 2'd0;
  localparam logic [1:0]  ST_STALL = 2'd1;
  localparam logic [1:0]  ST_HALT  = 2'd2;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [7:0]  redirect_pc_i;
  logic        halt_i;
  logic [31:0] fetch_cnt_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;

  if_stage_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .fetch_cnt_o   (fetch_cnt_o),
    .state_o       (state_o)
  );

  // Clock.
  always #5 clk = ~clk;

  // ROM contents: distinct word per address.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {8'hC0, 8'hDE, ~a, a};
  endfunction

  assign bus.inst_i = rom_word(bus.pc_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_slot(input string tag, input logic [7:0] pc);
    check({tag, ".valid"}, {31'd0, bus.id_valid_o}, 32'd1);
    check({tag, ".id_pc"}, {24'd0, bus.id_pc_o}, {24'd0, pc});
    check({tag, ".inst"},  bus.id_inst_o, rom_word(pc));
  endtask

  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0;
    bus.id_ready_i = 1'b0;
    #2;
    do_reset();

    // Reset state.
    check("rst.pc",    {24'd0, bus.pc_o}, 32'd0);
    check("rst.valid", {31'd0, bus.id_valid_o}, 32'd0);
    check("rst.id_pc", {24'd0, bus.id_pc_o}, 32'd0);
    check("rst.inst",  bus.id_inst_o, NOP);
    check("rst.cnt",   fetch_cnt_o, 32'd0);
    check("rst.state", {30'd0, state_o}, {30'd0, ST_RUN});

    // 1. Streaming with ready held high.
    bus.id_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_slot("stream", 8'(i));
      check("stream.cnt", fetch_cnt_o, 32'(i));
    end

    // 2. Back-pressure with slot at PC 2.
    do_reset();
    bus.id_ready_i = 1'b1;
    repeat (3) tick();
    check_slot("pre_stall", 8'd2);
    bus.id_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_slot("stall", 8'd2);
      check("stall.pc",    {24'd0, bus.pc_o}, 32'd3);
      check("stall.state", {30'd0, state_o}, {30'd0, ST_STALL});
      check("stall.cnt",   fetch_cnt_o, 32'd2);
    end
    bus.id_ready_i = 1'b1;
    tick();
    check_slot("unstall", 8'd3);
    check("unstall.state", {30'd0, state_o}, {30'd0, ST_RUN});
    check("unstall.cnt",   fetch_cnt_o, 32'd3);

    // 3. Redirect while slot holds PC 5.
    tick();
    tick();
    check_slot("pre_redir", 8'd5);
    redirect_i = 1'b1; redirect_pc_i = 8'h40;
    tick();
    redirect_i = 1'b0;
    check("redir.valid", {31'd0, bus.id_valid_o}, 32'd0);
    check("redir.inst",  bus.id_inst_o, NOP);
    check("redir.pc",    {24'd0, bus.pc_o}, 32'h40);
    check("redir.cnt",   fetch_cnt_o, 32'd5);
    tick();
    check_slot("redir_tgt", 8'h40);
    check("redir_tgt.cnt", fetch_cnt_o, 32'd5);

    // 4. Redirect to FE and wrap.
    redirect_i = 1'b1; redirect_pc_i = 8'hFE;
    tick();
    redirect_i = 1'b0;
    check("wrap.redir_cnt", fetch_cnt_o, 32'd5);
    tick();
    check_slot("wrap0", 8'hFE);
    tick();
    check_slot("wrap1", 8'hFF);
    tick();
    check_slot("wrap2", 8'h00);
    check("wrap.pc",  {24'd0, bus.pc_o}, 32'd1);
    check("wrap.cnt", fetch_cnt_o, 32'd7);

    // 5. Halt with ready high: drain then freeze.
    halt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt.valid", {31'd0, bus.id_valid_o}, 32'd0);
      check("halt.pc",    {24'd0, bus.pc_o}, 32'd1);
      check("halt.cnt",   fetch_cnt_o, 32'd8);
      check("halt.state", {30'd0, state_o}, {30'd0, ST_HALT});
    end
    halt_i = 1'b0;
    tick();
    check("unhalt.state", {30'd0, state_o}, {30'd0, ST_RUN});
    check("unhalt.pc",    {24'd0, bus.pc_o}, 32'd1);
    tick();
    check_slot("resume", 8'd1);
    check("resume.pc", {24'd0, bus.pc_o}, 32'd2);

    // 6. Reset in the middle of a stall with slot at PC 7.
    repeat (6) tick();
    check_slot("pre_rst", 8'd7);
    bus.id_ready_i = 1'b0;
    tick();
    check("pre_rst.state", {30'd0, state_o}, {30'd0, ST_STALL});
    do_reset();
    check("midrst.pc",    {24'd0, bus.pc_o}, 32'd0);
    check("midrst.valid", {31'd0, bus.id_valid_o}, 32'd0);
    check("midrst.cnt",   fetch_cnt_o, 32'd0);
    check("midrst.state", {30'd0, state_o}, {30'd0, ST_RUN});
    check("midrst.inst",  bus.id_inst_o, NOP);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
